// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-byte holding register
// and per-frame framing-error and overrun pulses.
module uart_rx #(
  parameter int clk_freq_hz = 100000000,
  parameter int baud_rate   = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int N    = clk_freq_hz / baud_rate;
  localparam int HALF = N / 2;
  localparam int CW   = $clog2(N);

  localparam logic [CW-1:0] CNT_BIT  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_s;
  logic          tick;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick   = (cnt == '0);
  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= CNT_HALF;
            state <= S_START;
          end
        end

        // Mid-start-bit check: a line already back high was only a glitch.
        S_START: begin
          if (tick) begin
            cnt <= CNT_BIT;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DATA: begin
          if (tick) begin
            cnt     <= CNT_BIT;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // A byte may load on the same edge the old one is accepted.
        S_STOP: begin
          if (tick) begin
            cnt <= CNT_BIT;
            if (rx_s) begin
              if (!o_valid || i_ready) begin
                o_data  <= shreg;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
              state <= S_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at N=10, HALF=5.
module tb_uart_rx;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] byte_q[$];
  logic [7:0] ov_q[$];
  int         fe_q[$];

  uart_rx #(
    .clk_freq_hz(1000000),
    .baud_rate  (100000)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(frame_err),
    .o_overrun  (overrun),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  // Called at a negedge; each bit is held for N cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [7:0] v;
    v = b;
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (N) @(negedge clk);
    end
    rx = stop;
    repeat (N) @(negedge clk);
    rx = 1'b1;
  endtask

  // Monitor: samples just after the negedge so inputs driven there are seen.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (valid && ready) begin
          if (byte_q.size() == 0) unexpected("unexpected_byte", data);
          else check("rx_byte", data, byte_q.pop_front());
        end
        if (frame_err) begin
          if (fe_q.size() == 0) unexpected("unexpected_frame_err", 1);
          else void'(fe_q.pop_front());
        end
        if (overrun) begin
          if (ov_q.size() == 0) unexpected("unexpected_overrun", data);
          else check("overrun_held_data", data, ov_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #12;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, consumer not ready: exact latency then hold.
    ready = 1'b0;
    byte_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (97) @(negedge clk);
        check("valid_before_e97", valid, 0);
        @(negedge clk);
        check("valid_at_e97", valid, 1);
        check("data_at_e97", data, 8'hA5);
      end
    join
    repeat (5) @(negedge clk);
    check("valid_hold", valid, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("valid_cleared", valid, 0);
    repeat (2) @(negedge clk);
    ready = 1'b1;
    repeat (10) @(negedge clk);

    // Back-to-back frames, zero gap.
    byte_q.push_back(8'h00);
    byte_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_drained", byte_q.size(), 0);

    // Glitch of 3 cycles: back to IDLE at edge 7.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_e2", busy, 1);
    repeat (4) @(negedge clk);
    check("glitch_busy_e6", busy, 1);
    @(negedge clk);
    check("glitch_idle_e7", busy, 0);
    check("glitch_no_valid", valid, 0);
    repeat (10) @(negedge clk);

    // Framing error followed by a line held low, then a good frame.
    fe_q.push_back(1);
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    check("wait_idle_busy", busy, 1);
    check("frame_err_no_valid", valid, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("wait_idle_released", busy, 0);
    check("frame_err_seen", fe_q.size(), 0);
    byte_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check("after_fe_drained", byte_q.size(), 0);

    // Overrun: second byte dropped while the first is held.
    ready = 1'b0;
    byte_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    ov_q.push_back(8'h11);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (97) @(negedge clk);
        check("overrun_before_e97", overrun, 0);
        @(negedge clk);
        check("overrun_at_e97", overrun, 1);
      end
    join
    check("overrun_data_kept", data, 8'h11);
    check("overrun_valid_kept", valid, 1);
    ready = 1'b1;
    @(negedge clk);
    check("overrun_accepted", valid, 0);
    check("overrun_seen", ov_q.size(), 0);
    check("overrun_drained", byte_q.size(), 0);
    repeat (10) @(negedge clk);

    // Asynchronous reset in bit 4 of 0xC3, then a clean 0x7E.
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (52) @(negedge clk);
        check("midframe_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    byte_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (10) @(negedge clk);

    check("final_byte_q", byte_q.size(), 0);
    check("final_fe_q", fe_q.size(), 0);
    check("final_ov_q", ov_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns 8N1 UART frames arriving on an asynchronous pin into bytes delivered on a valid/ready handshake. It is the receive counterpart of the existing `uart_tx` and shares its `clk_freq_hz`/`baud_rate` parameterisation, so both ends of a link are configured identically. It sits between the board RX pin and the SoC peripheral bus, with a one-byte holding register and per-frame error flags.

## Interface

- `clk_freq_hz`, default 100000000: system clock frequency in Hz.
- `baud_rate`, default 9600: line bit rate.
- Derived values:
  - `N = clk_freq_hz/baud_rate`, the number of clock cycles per bit. Integer division; N ≥ 4 is required.
  - `HALF = N/2`, using floor division.
  - The counter width is `$clog2(N)`.

- `i_clk` input 1: the single clock; all logic runs on its rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_uart_rx` input 1: serial line. It idles high and is asynchronous to `i_clk`.
- `o_data` output 8: received byte, held stable while `o_valid` is high.
- `o_valid` output 1: `o_data` holds an unconsumed byte.
- `i_ready` input 1: consumer accepts the byte when `o_valid & i_ready` at a clock edge.
- `o_frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `o_overrun` output 1: one-cycle pulse when a completed byte is dropped because the holding register is full.
- `o_busy` output 1: high whenever the FSM is not in IDLE.

## Operation

- **Synchronizer.** `i_uart_rx` passes through a two-flop synchronizer, giving `rx_s`. Both flops reset to 1. The FSM only ever looks at `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** when `rx_s==0`, load `cnt = HALF-1` and go to START.
- **Counter.** In START, DATA and STOP, `cnt` decrements each cycle. The state's action fires on the edge where `cnt==0`, and that edge reloads `cnt = N-1`.
- **START** (mid-start-bit check):
  - If `rx_s==1`, this is a glitch: go back to IDLE. No flags, no output.
  - If `rx_s==0`, clear the bit index and go to DATA.
- **DATA:** shift `rx_s` into the shift register, LSB first. After the 8th bit, go to STOP.
- **STOP** (sample the stop bit):
  - If `rx_s==1` (valid frame):
    - Holding register empty, or being accepted this same edge: load `o_data`, set `o_valid=1`. Go to IDLE.
    - Otherwise: keep the old `o_data`/`o_valid`, pulse `o_overrun`, discard the new byte. Go to IDLE.
  - If `rx_s==0`: pulse `o_frame_err`, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s==1`, then go to IDLE. This prevents a break condition from being taken as repeated frames.
- **Handshake:**
  - `o_valid` clears on an edge with `i_ready==1`, unless a new byte loads on that same edge; in that case `o_valid` stays 1 and `o_data` updates.
  - `i_ready` while `o_valid==0` has no effect.
- **Reset:** asserting `i_rst_n` at any time, including mid-frame, returns all state to the reset values immediately. The next frame that starts after release is received normally.

## Timing

- **Reset values:**
  - `o_data=8'h00`, `o_valid=0`, `o_frame_err=0`, `o_overrun=0`, `o_busy=0`.
  - FSM in IDLE, `cnt=0`, shift register 0, synchronizer flops 1.
- **Latency,** counting edge 0 as the edge where the synchronizer's first flop captures the falling start edge:
  - Edge 2: leave IDLE; `o_busy` goes high after this edge.
  - Edge 2+HALF: start-bit check.
  - Edge 2+HALF+k·N, k=1..8: data bit k-1 sampled.
  - Edge 2+HALF+9·N: stop bit sampled; `o_valid`, `o_frame_err` or `o_overrun` updates on this edge.
- **Pulse width:** `o_frame_err` and `o_overrun` are high for exactly one cycle.
- **Back-to-back frames:** the FSM is back in IDLE after the stop-sample edge, with about N/2 cycles of stop bit left. This allows zero-gap frames.
- **Baud tolerance:** sampling is at bit centre, with floor rounding of N and HALF. Must tolerate ±2% baud mismatch.

## Test plan

Use `clk_freq_hz=1000000`, `baud_rate=100000`, which gives N=10 and HALF=5. Hold `i_ready=1` unless a scenario says otherwise.

- **Single byte.** Send 0xA5 with `i_ready=0` → `o_valid` rises at edge 97 with `o_data=8'hA5`. It holds until `i_ready` pulses, then clears the following edge.
- **Back-to-back.** Send 0x00 then 0xFF with no idle gap, `i_ready=1` → two accepted bytes 0x00 and 0xFF; no `o_frame_err`, no `o_overrun`.
- **Glitch rejection.** Drive `i_uart_rx` low for 3 cycles, then high → FSM returns to IDLE at edge 7; `o_valid`, `o_frame_err` and `o_overrun` stay 0.
- **Framing error.** Send 0x55 with the stop bit low, then hold the line low for 30 cycles → one-cycle `o_frame_err`, `o_valid` stays 0. `o_busy` stays high until the line returns high. A following 0x3C is then received correctly.
- **Overrun.** Send 0x11 then 0x22 with `i_ready=0` throughout → `o_data` stays 8'h11, and `o_overrun` pulses once at the second stop-sample edge.
- **Reset mid-frame.** Pull `i_rst_n` low during bit 4 of 0xC3 → all outputs go to 0 asynchronously. After release, 0x7E is received correctly.
